// File: rtl/mining_result_tx.sv
// mining_result_tx
// UART 8N1 transmitter for the mining controller's result. It sends the
// status text with null bytes removed, a space, the nonce as eight uppercase
// hex digits, and then CR LF. msg and nonce are captured when the report
// starts, so later changes on those inputs do not affect a report in flight.

module mining_result_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [63:0] msg,
  input  logic [31:0] nonce,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        IDX_MSG_LAST = 5'd7;
  localparam logic [4:0]        IDX_LAST     = 5'd18;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Convert a nibble to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
    else             c = 8'h37 + {4'h0, nib};
    return c;
  endfunction

  // Return the report byte at index idx: message bytes, space, hex nonce, CR, LF.
  function automatic logic [7:0] report_byte(input logic [4:0]  idx,
                                             input logic [63:0] m,
                                             input logic [31:0] n);
    logic [63:0] m_sh;
    logic [31:0] n_sh;
    logic [7:0]  b;
    m_sh = m << {idx[2:0], 3'b000};
    // For idx 9..16, the low three bits minus one give nibble 0..7.
    n_sh = n << {idx[2:0] - 3'd1, 2'b00};
    if (idx <= IDX_MSG_LAST)  b = m_sh[63:56];
    else if (idx == 5'd8)     b = 8'h20;
    else if (idx <= 5'd16)    b = hex_ascii(n_sh[31:28]);
    else if (idx == 5'd17)    b = 8'h0D;
    else                      b = 8'h0A;
    return b;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [4:0]        idx_r, idx_nxt_s;
  logic [2:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic [BAUD_W-1:0] baud_r, baud_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic [63:0]       msg_r, msg_nxt_s;
  logic [31:0]       nonce_r, nonce_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic [7:0]        cur_byte_s;
  logic              baud_last_s;

  assign cur_byte_s  = report_byte(idx_r, msg_r, nonce_r);
  assign baud_last_s = (baud_r == BAUD_LAST);

  // State and datapath registers; reset abandons any report in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      idx_r     <= 5'd0;
      bit_cnt_r <= 3'd0;
      baud_r    <= '0;
      shift_r   <= 8'h00;
      msg_r     <= 64'h0;
      nonce_r   <= 32'h0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      baud_r    <= baud_nxt_s;
      shift_r   <= shift_nxt_s;
      msg_r     <= msg_nxt_s;
      nonce_r   <= nonce_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  // Next-state and next-output logic; tx/busy/done are computed one edge ahead.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    bit_cnt_nxt_s = bit_cnt_r;
    baud_nxt_s    = baud_r;
    shift_nxt_s   = shift_r;
    msg_nxt_s     = msg_r;
    nonce_nxt_s   = nonce_r;
    tx_nxt_s      = tx_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        tx_nxt_s = 1'b1;
        if (send) begin
          msg_nxt_s   = msg;
          nonce_nxt_s = nonce;
          idx_nxt_s   = 5'd0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = S_SELECT;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end

      S_SELECT: begin
        // Skip null padding bytes in the message, one index per cycle.
        if ((idx_r <= IDX_MSG_LAST) && (cur_byte_s == 8'h00)) begin
          idx_nxt_s = idx_r + 5'd1;
        end else begin
          shift_nxt_s = cur_byte_s;
          baud_nxt_s  = '0;
          tx_nxt_s    = 1'b0;
          state_nxt_s = S_START;
        end
      end

      S_START: begin
        if (baud_last_s) begin
          baud_nxt_s    = '0;
          bit_cnt_nxt_s = 3'd0;
          tx_nxt_s      = shift_r[0];
          state_nxt_s   = S_DATA;
        end else begin
          baud_nxt_s    = baud_r + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last_s) begin
          baud_nxt_s = '0;
          if (bit_cnt_r == 3'd7) begin
            tx_nxt_s    = 1'b1;
            state_nxt_s = S_STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            shift_nxt_s   = {1'b0, shift_r[7:1]};
            tx_nxt_s      = shift_r[1];
          end
        end else begin
          baud_nxt_s = baud_r + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_last_s) begin
          baud_nxt_s = '0;
          if (idx_r == IDX_LAST) begin
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            state_nxt_s = S_DONE;
          end else begin
            idx_nxt_s   = idx_r + 5'd1;
            state_nxt_s = S_SELECT;
          end
        end else begin
          baud_nxt_s = baud_r + 1'b1;
        end
      end

      S_DONE: begin
        // A send seen in this cycle is dropped; the next IDLE cycle accepts it.
        busy_nxt_s  = 1'b0;
        tx_nxt_s    = 1'b1;
        state_nxt_s = S_IDLE;
      end

      default: begin
        busy_nxt_s  = 1'b0;
        tx_nxt_s    = 1'b1;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mining_result_tx.sv
// Testbench for mining_result_tx. A reference model builds the expected
// per-cycle tx/busy/done waveform of a report from its byte list and the
// documented timing. DUT outputs are compared with that waveform on every
// falling clock edge.

module tb_mining_result_tx;

  localparam int CPB = 4;

  logic        clock;
  logic        reset;
  logic        send;
  logic [63:0] msg;
  logic [31:0] nonce;
  logic        tx;
  logic        busy;
  logic        done;

  int errors;
  int checks;

  mining_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .send  (send),
    .msg   (msg),
    .nonce (nonce),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check the idle outputs for n cycles.
  task automatic idle_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check($sformatf("%s_idle_tx", name), 64'(tx), 64'd1);
      check($sformatf("%s_idle_busy", name), 64'(busy), 64'd0);
      check($sformatf("%s_idle_done", name), 64'(done), 64'd0);
    end
  endtask

  // Run one report against the model and compare every cycle.
  // inj_frame: during that frame, pulse send with other data (-1 = none).
  // rst_frame: assert reset mid-DATA of that frame and abandon (-1 = none).
  // early: raise send (with nm/nn) in the DONE cycle to start the next report.
  task automatic run_report(input string name, input logic [63:0] m, input logic [31:0] n,
                            input int inj_frame, input int rst_frame, input bit early,
                            input logic [63:0] nm, input logic [31:0] nn);
    byte unsigned bytes_q[$];
    int           skips_q[$];
    int           start_q[$];
    bit           tx_e[$];
    bit           busy_e[$];
    bit           done_e[$];
    int           pending;
    int           p;
    int           st;
    int           len;
    int           inj_at;
    int           rst_at;
    byte unsigned b;
    logic [3:0]   d;

    // Byte list: non-null message bytes, space, hex nonce, CR, LF.
    pending = 0;
    for (int i = 0; i < 8; i++) begin
      b = 8'(m >> (56 - 8 * i));
      if (b == 8'h00) begin
        pending++;
      end else begin
        bytes_q.push_back(b);
        skips_q.push_back(pending);
        pending = 0;
      end
    end
    bytes_q.push_back(8'h20);
    skips_q.push_back(pending);
    for (int k = 0; k < 8; k++) begin
      d = 4'(n >> (28 - 4 * k));
      bytes_q.push_back((d < 4'd10) ? (8'h30 + 8'(d)) : (8'h41 + 8'(d) - 8'd10));
      skips_q.push_back(0);
    end
    bytes_q.push_back(8'h0D);
    skips_q.push_back(0);
    bytes_q.push_back(8'h0A);
    skips_q.push_back(0);

    // Expected waveform. Offset 0 is the capture edge.
    tx_e.push_back(1'b1); busy_e.push_back(1'b1); done_e.push_back(1'b0);
    p = 0;
    foreach (bytes_q[f]) begin
      st = p + 1 + skips_q[f];
      start_q.push_back(st);
      while (tx_e.size() < st) begin
        tx_e.push_back(1'b1); busy_e.push_back(1'b1); done_e.push_back(1'b0);
      end
      for (int o = 0; o < 10 * CPB; o++) begin
        if (o < CPB)          tx_e.push_back(1'b0);
        else if (o < 9 * CPB) tx_e.push_back(bytes_q[f][(o - CPB) / CPB]);
        else                  tx_e.push_back(1'b1);
        busy_e.push_back(1'b1);
        done_e.push_back(1'b0);
      end
      p = st + 10 * CPB;
    end
    tx_e.push_back(1'b1); busy_e.push_back(1'b0); done_e.push_back(1'b1);
    tx_e.push_back(1'b1); busy_e.push_back(1'b0); done_e.push_back(1'b0);
    len = tx_e.size();

    inj_at = (inj_frame >= 0) ? start_q[inj_frame] + 5 : -10;
    rst_at = (rst_frame >= 0) ? start_q[rst_frame] + 2 * CPB + 1 : -10;

    send  = 1'b1;
    msg   = m;
    nonce = n;
    @(posedge clock);
    for (int j = 0; j < len; j++) begin
      @(negedge clock);
      if (j == 0) begin
        // Change the inputs after capture; the report must not follow them.
        send  = 1'b0;
        msg   = {$urandom, $urandom};
        nonce = $urandom;
      end
      if (j == inj_at) begin
        send  = 1'b1;
        msg   = ~m;
        nonce = ~n;
      end
      if (j == inj_at + 1) send = 1'b0;
      if (j == rst_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_rst_tx", name), 64'(tx), 64'd1);
        check($sformatf("%s_rst_busy", name), 64'(busy), 64'd0);
        check($sformatf("%s_rst_done", name), 64'(done), 64'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check($sformatf("%s_rsthold_tx", name), 64'(tx), 64'd1);
          check($sformatf("%s_rsthold_done", name), 64'(done), 64'd0);
        end
        reset = 1'b1;
        return;
      end
      check($sformatf("%s_tx@%0d", name, j), 64'(tx), 64'(tx_e[j]));
      check($sformatf("%s_busy@%0d", name, j), 64'(busy), 64'(busy_e[j]));
      check($sformatf("%s_done@%0d", name, j), 64'(done), 64'(done_e[j]));
      if (early && (j == len - 2)) begin
        send  = 1'b1;
        msg   = nm;
        nonce = nn;
      end
    end
  endtask

  // Random message with about a third of the bytes null.
  function automatic logic [63:0] rand_msg();
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++) begin
      r = r << 8;
      if ($urandom_range(0, 2) != 0) r[7:0] = 8'($urandom_range(1, 255));
      else                           r[7:0] = 8'h00;
    end
    return r;
  endfunction

  // Main stimulus sequence.
  initial begin
    logic [63:0] rm;
    logic [31:0] rn;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    send   = 1'b0;
    msg    = 64'h0;
    nonce  = 32'h0;

    repeat (3) @(negedge clock);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b1;
    idle_cycles("post_reset", 2);

    run_report("niente", 64'h004E69656E746521, 32'h0000002A, -1, -1, 1'b0, 64'h0, 32'h0);
    idle_cycles("gap1", 2);
    run_report("trovato_inj", 64'h54726F7661746F21, 32'hFFFFFFFF, 2, -1, 1'b0, 64'h0, 32'h0);
    run_report("allnull", 64'h0000000000000000, 32'h89ABCDEF, -1, -1, 1'b1,
               64'h4E00690000000021, 32'h1234ABCD);
    run_report("interior", 64'h4E00690000000021, 32'h1234ABCD, -1, -1, 1'b0, 64'h0, 32'h0);
    idle_cycles("gap2", 1);
    run_report("reset_mid", 64'h54726F7661746F21, 32'hDEADBEEF, -1, 4, 1'b0, 64'h0, 32'h0);
    idle_cycles("after_rst", 2);
    run_report("post_rst", 64'h004E69656E746521, 32'h0BADF00D, -1, -1, 1'b0, 64'h0, 32'h0);

    for (int t = 0; t < 4; t++) begin
      rm = rand_msg();
      rn = $urandom;
      idle_cycles($sformatf("rgap%0d", t), $urandom_range(0, 3));
      run_report($sformatf("rand%0d", t), rm, rn, -1, -1, 1'b0, 64'h0, 32'h0);
    end
    idle_cycles("final", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
